// File: rtl/seg_display_ctrl.sv
// Bus-mapped four-digit seven-segment scanner. Software writes a 16-bit hex value
// and a control word; the block multiplexes the common-anode digits on its own.
module seg_display_ctrl #(
  parameter int          SCAN_DIV  = 50000,
  parameter logic [31:0] BASE_ADDR = 32'h40000020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] Write_Data,
  output logic [31:0] Read_Data,
  output logic [3:0]  an,
  output logic [7:0]  seg
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    REG_VALUE  = 2'd0,
    REG_CTRL   = 2'd1,
    REG_STATUS = 2'd2,
    REG_RSVD   = 2'd3
  } reg_sel_e;

  logic [15:0]      value_q;
  logic [11:0]      ctrl_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       digit_q;
  logic [15:0]      frame_q;

  logic             sel;
  reg_sel_e         reg_idx;
  logic             en;
  logic [3:0]       dp_mask;
  logic [3:0]       blank_mask;
  logic [3:0]       nibble;
  logic [3:0]       an_d;
  logic [7:0]       seg_d;

  // Byte-lane bits and the upper store bits have no home in any register.
  logic unused_bits;
  assign unused_bits = ^{Addr[1:0], Write_Data[31:16]};

  assign sel        = (Addr[31:4] == BASE_ADDR[31:4]);
  assign reg_idx    = reg_sel_e'(Addr[3:2]);
  assign en         = ctrl_q[0];
  assign dp_mask    = ctrl_q[7:4];
  assign blank_mask = ctrl_q[11:8];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
      ctrl_q  <= '0;
    end else if (MemWrite && sel) begin
      case (reg_idx)
        REG_VALUE: value_q <= Write_Data[15:0];
        REG_CTRL:  ctrl_q  <= Write_Data[11:0];
        default:   ;
      endcase
    end
  end

  // NOTE: give every always_comb output a default first; a path that leaves
  // one unassigned infers a latch.
  always_comb begin
    Read_Data = 32'h0;
    if (MemRead && sel) begin
      case (reg_idx)
        REG_VALUE:  Read_Data = {16'h0, value_q};
        REG_CTRL:   Read_Data = {20'h0, ctrl_q};
        REG_STATUS: Read_Data = {frame_q, 14'h0, digit_q};
        default:    Read_Data = 32'h0;
      endcase
    end
  end

  // Dwell divider and digit index; held at zero while disabled so a re-enable
  // always restarts on digit 0 with a full dwell.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      digit_q <= '0;
      frame_q <= '0;
    end else if (!en) begin
      cnt_q   <= '0;
      digit_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q   <= '0;
      digit_q <= digit_q + 2'd1;
      if (digit_q == 2'd3) frame_q <= frame_q + 16'd1;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  assign nibble = value_q[{digit_q, 2'b00} +: 4];

  always_comb begin
    an_d  = 4'hF;
    seg_d = 8'hFF;
    if (en && !blank_mask[digit_q]) begin
      an_d  = ~(4'b0001 << digit_q);
      seg_d = {~dp_mask[digit_q], hex_to_seg(nibble)};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= 4'hF;
      seg <= 8'hFF;
    end else begin
      an  <= an_d;
      seg <= seg_d;
    end
  end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Bench for seg_display_ctrl: stimulus pushes expected display/read values into
// queues, a monitor pops and compares them at each falling edge.
module tb_seg_display_ctrl;

  localparam int          SD    = 4;
  localparam logic [31:0] BASE  = 32'h40000020;
  localparam logic [31:0] A_VAL = BASE;
  localparam logic [31:0] A_CTL = BASE + 32'd4;
  localparam logic [31:0] A_STS = BASE + 32'd8;
  localparam logic [31:0] A_RSV = BASE + 32'd12;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] Addr = '0;
  logic [31:0] Write_Data = '0;
  logic [31:0] Read_Data;
  logic [3:0]  an;
  logic [7:0]  seg;

  typedef struct {
    string       name;
    logic [11:0] exp;
    logic [11:0] mask;
  } disp_t;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } rd_t;

  disp_t disp_q[$];
  rd_t   rd_q[$];
  int    checks = 0;
  int    errors = 0;
  event  sample_ev;

  logic [7:0] dec [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  seg_display_ctrl #(.SCAN_DIV(SD), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
    .Addr(Addr), .Write_Data(Write_Data), .Read_Data(Read_Data),
    .an(an), .seg(seg)
  );

  initial forever #5 clk = clk_en ? ~clk : 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    disp_t d;
    rd_t   r;
    forever begin
      @(negedge clk or sample_ev);
      if (disp_q.size() > 0) begin
        d = disp_q.pop_front();
        check(d.name, 32'({an, seg} & d.mask), 32'(d.exp & d.mask));
      end
      if (rd_q.size() > 0) begin
        r = rd_q.pop_front();
        check(r.name, Read_Data, r.exp);
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] wd);
    Addr = a; Write_Data = wd; MemWrite = 1'b1;
    run(1);
    MemWrite = 1'b0;
  endtask

  task automatic bus_read(input string name, input logic [31:0] a, input logic [31:0] exp);
    Addr = a; MemRead = 1'b1;
    rd_q.push_back('{name: name, exp: exp});
    run(1);
    MemRead = 1'b0;
  endtask

  task automatic expect_disp(input string name, input logic [3:0] a, input logic [7:0] s, input int n);
    for (int i = 0; i < n; i++) disp_q.push_back('{name: name, exp: {a, s}, mask: 12'hFFF});
  endtask

  initial begin
    #2 rst = 1'b1;
    #2;
    expect_disp("reset_dark_noclk", 4'hF, 8'hFF, 1);
    -> sample_ev;
    #2 clk_en = 1'b1;
    run(2);
    rst = 1'b0;

    bus_read("rst_value", A_VAL, 32'h0);
    bus_read("rst_ctrl", A_CTL, 32'h0);
    bus_read("rst_status", A_STS, 32'h0);

    // Basic scan of 0x1234, right digit first.
    bus_write(A_VAL, 32'h1234);
    bus_write(A_CTL, 32'h1);
    run(1);
    expect_disp("scan_d0", 4'hE, 8'h99, SD);
    expect_disp("scan_d1", 4'hD, 8'hB0, SD);
    expect_disp("scan_d2", 4'hB, 8'hA4, SD);
    expect_disp("scan_d3", 4'h7, 8'hF9, SD);
    run(4 * SD);
    bus_read("frame_one", A_STS, 32'h0001_0000);

    // dp on digit 0, digit 1 blanked.
    bus_write(A_CTL, 32'h0);
    bus_write(A_VAL, 32'h00F0);
    bus_write(A_CTL, 32'h0211);
    run(1);
    expect_disp("mask_d0_dp", 4'hE, 8'h40, SD);
    expect_disp("mask_d1_blank", 4'hF, 8'hFF, SD);
    expect_disp("mask_d2", 4'hB, 8'hC0, SD);
    expect_disp("mask_d3", 4'h7, 8'hC0, SD);
    run(4 * SD);

    // Decode sweep: every digit carries the same nibble, so only seg is compared.
    bus_write(A_CTL, 32'h1);
    for (int n = 0; n < 16; n++) begin
      bus_write(A_VAL, {16'h0, {4{4'(n)}}});
      run(1);
      disp_q.push_back('{name: $sformatf("decode_%0h", n), exp: {4'h0, dec[n]}, mask: 12'h0FF});
      run(1);
    end

    // Disable during digit 2, then re-enable for a fresh full dwell on digit 0.
    bus_write(A_CTL, 32'h0);
    bus_write(A_VAL, 32'h1234);
    bus_write(A_CTL, 32'h1);
    run(2 * SD + 1);
    bus_write(A_CTL, 32'h0);
    expect_disp("pre_disable_d2", 4'hB, 8'hA4, 1);
    expect_disp("disabled_dark", 4'hF, 8'hFF, 3);
    run(4);
    bus_write(A_CTL, 32'h1);
    run(1);
    expect_disp("reenable_d0", 4'hE, 8'h99, SD);
    expect_disp("reenable_d1", 4'hD, 8'hB0, 1);
    run(SD + 1);

    // Reset mid-dwell must darken outputs without a clock edge.
    rst = 1'b1;
    #1;
    expect_disp("async_rst_dark", 4'hF, 8'hFF, 1);
    -> sample_ev;
    run(2);
    rst = 1'b0;
    bus_read("midrst_value", A_VAL, 32'h0);
    bus_read("midrst_ctrl", A_CTL, 32'h0);
    bus_read("midrst_status", A_STS, 32'h0);

    // Bus isolation.
    bus_write(A_VAL, 32'h0000_AAAA);
    bus_read("unmapped_read", 32'h4000_0030, 32'h0);
    Addr = A_VAL;
    rd_q.push_back('{name: "no_memread", exp: 32'h0});
    run(1);
    bus_write(A_STS, 32'hFFFF_FFFF);
    bus_read("status_write_ignored", A_STS, 32'h0);
    bus_write(32'h5000_0020, 32'h1111);
    bus_write(A_RSV, 32'h2222);
    bus_write(32'h4000_0030, 32'h3333);
    bus_read("value_unchanged", A_VAL, 32'h0000_AAAA);
    bus_read("reserved_zero", A_RSV, 32'h0);
    bus_read("byte_lane_ignored", A_VAL + 32'd3, 32'h0000_AAAA);
    bus_write(A_CTL, 32'hFFFF_FFFE);
    bus_read("ctrl_unused_bits", A_CTL, 32'h0000_0FFE);

    Addr = A_VAL; Write_Data = 32'h0000_5555; MemRead = 1'b1; MemWrite = 1'b1;
    rd_q.push_back('{name: "same_cycle_old", exp: 32'h0000_AAAA});
    run(1);
    MemRead = 1'b0; MemWrite = 1'b0;
    bus_read("same_cycle_new", A_VAL, 32'h0000_5555);

    run(2);
    check("queues_drained", 32'(disp_q.size() + rd_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
